// File: rtl/mtm_alu_serializer.sv
// rtl/mtm_alu_serializer.sv - serializes ALU results into MTM frames on a single wire
module mtm_alu_serializer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] C_in,
    input  logic [7:0]  CTL_in,
    output logic        sout,
    output logic        busy,
    output logic        drop
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] CLK_LAST = 4'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'd10;

    state_t      state_q, state_d;
    logic [31:0] c_q, c_d;
    logic [7:0]  ctl_q, ctl_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_c_q, pend_c_d;
    logic [7:0]  pend_ctl_q, pend_ctl_d;
    logic [3:0]  clk_cnt_q, clk_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  frame_cnt_q, frame_cnt_d;
    logic        sout_q, sout_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;

    logic        in_valid;
    logic        pkt_done;
    logic [2:0]  frame_last;

    // Bit value on the line for a given frame/bit position of the captured packet.
    function automatic logic frame_bit(input logic [31:0] c, input logic [7:0] ctl,
                                       input logic [2:0] frame, input logic [3:0] bitn);
        logic [7:0] b;
        logic       t;
        logic [3:0] idx;
        logic       r;
        if (ctl[7]) begin
            b = ctl;
            t = 1'b1;
        end else begin
            t = (frame == 3'd4);
            case (frame)
                3'd0:    b = c[31:24];
                3'd1:    b = c[23:16];
                3'd2:    b = c[15:8];
                3'd3:    b = c[7:0];
                default: b = ctl;
            endcase
        end
        idx = 4'd9 - bitn;
        case (bitn)
            4'd0:    r = 1'b0;
            4'd1:    r = t;
            4'd10:   r = 1'b1;
            default: r = b[idx[2:0]];
        endcase
        return r;
    endfunction

    assign in_valid   = (CTL_in != 8'hFF);
    assign frame_last = ctl_q[7] ? 3'd0 : 3'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            ctl_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_c_q     <= '0;
            pend_ctl_q   <= '0;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            sout_q       <= 1'b1;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            ctl_q        <= ctl_d;
            pend_valid_q <= pend_valid_d;
            pend_c_q     <= pend_c_d;
            pend_ctl_q   <= pend_ctl_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            sout_q       <= sout_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        ctl_d        = ctl_q;
        pend_valid_d = pend_valid_q;
        pend_c_d     = pend_c_q;
        pend_ctl_d   = pend_ctl_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        sout_d       = sout_q;
        drop_d       = 1'b0;
        pkt_done     = 1'b0;

        case (state_q)
            IDLE: begin
                sout_d = 1'b1;
                if (in_valid) begin
                    c_d         = C_in;
                    ctl_d       = CTL_in;
                    clk_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    sout_d      = 1'b0;
                    state_d     = SEND;
                end
            end
            default: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (frame_cnt_q == frame_last) begin
                            pkt_done = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 4'd1;
                end
                sout_d = frame_bit(c_q, ctl_q, frame_cnt_d, bit_cnt_d);

                // End of packet: pending goes first, a same-edge input then takes its slot.
                if (pkt_done) begin
                    frame_cnt_d = '0;
                    sout_d      = 1'b0;
                    if (pend_valid_q) begin
                        c_d          = pend_c_q;
                        ctl_d        = pend_ctl_q;
                        pend_valid_d = in_valid;
                        if (in_valid) begin
                            pend_c_d   = C_in;
                            pend_ctl_d = CTL_in;
                        end
                    end else if (in_valid) begin
                        c_d   = C_in;
                        ctl_d = CTL_in;
                    end else begin
                        state_d = IDLE;
                        sout_d  = 1'b1;
                    end
                end else if (in_valid) begin
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_c_d     = C_in;
                        pend_ctl_d   = CTL_in;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d == SEND) || pend_valid_d;
    end

    always_comb begin
        sout = sout_q;
        busy = busy_q;
        drop = drop_q;
    end

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
- Output stage directly downstream of the ALU core. Consumes the registered result word (C) and status/CRC byte (CTL_out) the core produces each cycle.
- Transmits each result on a single-wire serial line using the MTM ALU frame format.
- Holds one result in flight plus one pending result, so back-to-back core results are not lost.

Parameters:
- CLKS_PER_BIT, 1, clock cycles each serial bit is held on sout (legal range 1..16).

Ports:
- clk     input   1   system clock; all logic on rising edge
- rst     input   1   synchronous reset, active-high
- C_in    input   32  result word from the ALU core (core output C)
- CTL_in  input   8   status/CRC or error byte from the ALU core (core output CTL_out)
- sout    output  1   serial output; idles high
- busy    output  1   high while a packet is being sent or a result is pending
- drop    output  1   one-cycle pulse when an incoming result is discarded

Behaviour:
- Reset and clocking: one clock, synchronous active-high reset. Reset dominates any other event on the same edge.
- Reset values: sout=1, busy=0, drop=0. Pending buffer empty, FSM in IDLE, all counters 0.
- Valid input: a cycle with CTL_in != 8'hFF is a result. 8'hFF means idle and is ignored. Upstream presents each result for exactly one cycle.
- Packet classification:
  - CTL_in[7]=0: data packet. Five frames in order C_in[31:24], C_in[23:16], C_in[15:8], C_in[7:0], then CTL_in.
  - CTL_in[7]=1: error packet. One frame carrying CTL_in only.
- Frame format (11 bits, in transmit order):
  - start 0
  - type bit: 0 for a data byte, 1 for the CTL byte
  - byte bits 7 down to 0 (MSB first)
  - stop 1
- Frames within a packet are back-to-back with no idle bits. Data packet = 55 bits; error packet = 11 bits.
- Bit timing: each bit is held for exactly CLKS_PER_BIT cycles. sout is driven from a register.
- FSM states:
  - IDLE: valid input on edge k → capture C_in/CTL_in, drive sout<=0 (start bit) on edge k, go to SEND. First start bit is visible in the cycle after edge k.
  - SEND: counters clk_cnt (0..CLKS_PER_BIT-1), bit_cnt (0..10), frame_cnt (0..4 for data, 0 for error).
    - After the last cycle of the final stop bit: if pending is valid, load it and emit its start bit on that same edge (no gap), then clear pending.
    - Otherwise go to IDLE with sout=1.
- Pending buffer (depth 1):
  - Valid input while in SEND and pending empty → store it in pending.
  - Valid input while in SEND and pending full → discard it and drive drop=1 for the next cycle only. The in-flight packet and the pending entry are unaffected.
  - Valid input on the same edge the final stop bit completes, with pending empty → starts directly as the next packet, no gap.
  - Same situation with pending full → pending packet starts; the new input goes into the freed pending slot (not dropped).
- busy = (state==SEND) or pending valid, registered. It rises on the capture edge and falls on the edge that returns the FSM to IDLE.
- Reset mid-packet: the frame is abandoned. sout=1 from the next cycle; pending is cleared; no partial frame resumes.
- Captured data is a stable copy: later changes on C_in/CTL_in do not affect the frame in flight.

Test Plan:
- CLKS_PER_BIT=1. Present C_in=32'h12345678, CTL_in=8'h23 for one cycle → 55 bits on sout, first frame 0,0,00010010,1, last frame 0,1,00100011,1. busy high for exactly 55 cycles. sout=1 afterwards.
- CTL_in=8'hA5 (error), C_in=32'hDEADBEEF → single frame 0,1,10100101,1. busy high for 11 cycles. C_in never appears on sout.
- Two data results 3 cycles apart (0x00000001/CTL 0x04, then 0xFFFFFFFF/CTL 0x4A) → second packet's start bit immediately follows the first packet's stop bit (110 contiguous bits). drop never asserted.
- Three results on consecutive valid cycles during one packet → first sent, second pending, third discarded. drop high exactly one cycle. Only two packets appear on sout.
- CLKS_PER_BIT=4, error byte 8'hC9 → each bit held 4 cycles. Frame lasts 44 cycles.
- Assert rst for 1 cycle at bit 20 of a data packet, with another result pending → sout=1, busy=0 the next cycle. No further frames until a new valid input arrives.
